// File: rtl/timer_pkg.sv
// Shared types for the bus-mapped countdown timer: register offsets and
// the control register layout.
package timer_pkg;

    localparam int DATA_W = 32;

    // Word offsets inside the eight-word register window.
    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_LOAD     = 3'd1,
        OFF_COUNT    = 3'd2,
        OFF_STATUS   = 3'd3,
        OFF_PRESCALE = 3'd4
    } offset_e;

    // CTRL[2:0]; the first member is the most significant bit.
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..period and emits a one-cycle tick on the cycle the
// count equals period. Held at zero while disabled.
module tick_gen
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] period,
    output logic              tick
);

    logic [DATA_W-1:0] cnt;

    // A period of zero matches every enabled cycle, so it ticks continuously.
    assign tick = en && (cnt == period);

    // Prescaler counter: wraps on tick, restarts on disable or on a new period.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// CPU-visible countdown timer with prescaler, auto-reload and a level
// interrupt. Registers live in an eight-word window at BASE_ADDR, which
// must be aligned so that bits [2:0] are zero.
module bus_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        rst,
    inout  tri   [31:0] data,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic        irq
);

    logic              sel;
    logic              wr_sel;
    offset_e           off;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] load_reg;
    logic [DATA_W-1:0] count_reg;
    logic [DATA_W-1:0] prescale_reg;
    logic              pending;
    logic              tick;
    logic              expire;
    logic [DATA_W-1:0] rdata;

    assign sel    = (rd || wr) && (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_sel = wr && sel;
    assign off    = offset_e'(addr[2:0]);

    // A tick that finds COUNT already at zero is an expiry.
    assign expire = tick && (count_reg == '0);

    assign irq = pending && ctrl.irq_en;

    tick_gen u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.en),
        .clr   (wr_sel && (off == OFF_PRESCALE)),
        .period(prescale_reg),
        .tick  (tick)
    );

    // Read mux for the selected register; reserved offsets read zero.
    // NOTE: rdata gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = {29'b0, ctrl};
            OFF_LOAD:     rdata = load_reg;
            OFF_COUNT:    rdata = count_reg;
            OFF_STATUS:   rdata = {31'b0, pending};
            OFF_PRESCALE: rdata = prescale_reg;
            default:      rdata = '0;
        endcase
    end

    // The shared bus is driven only during a selected read.
    assign data = (sel && rd && !wr) ? rdata : 'z;

    // CTRL: a CPU write beats the one-shot expiry that would clear en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= '0;
        end else if (wr_sel && (off == OFF_CTRL)) begin
            ctrl <= ctrl_t'(data[2:0]);
        end else if (expire && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    // LOAD and PRESCALE are plain CPU-written registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_reg     <= '0;
            prescale_reg <= '0;
        end else if (wr_sel) begin
            if (off == OFF_LOAD)     load_reg     <= data;
            if (off == OFF_PRESCALE) prescale_reg <= data;
        end
    end

    // COUNT: CPU write first, then reload/hold on expiry, else decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (wr_sel && (off == OFF_COUNT)) begin
            count_reg <= data;
        end else if (expire) begin
            count_reg <= ctrl.auto_reload ? load_reg : '0;
        end else if (tick) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Pending flag: set on expiry, which beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (expire) begin
            pending <= 1'b1;
        end else if (wr_sel && (off == OFF_STATUS) && data[0]) begin
            pending <= 1'b0;
        end
    end

endmodule
